// File: rtl/mem_arbiter.sv
// Arbitrates one single-port RAM between instruction fetch and data load/store.
// Data wins by default; a streak counter forces a fetch after MAX_DSTREAK data grants.
module mem_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned WORD_W      = 32,
    parameter int unsigned MAX_DSTREAK = 4
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [WORD_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic              dwait,
    output logic [WORD_W-1:0] dload,
    output logic              ram_REN,
    output logic              ram_WEN,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [WORD_W-1:0] ram_store,
    input  logic [WORD_W-1:0] ram_load,
    input  logic              ram_ready
);
    typedef enum logic [1:0] {IDLE, IACC, DACC} state_t;

    localparam logic [3:0] MAX_S = 4'(MAX_DSTREAK);

    state_t     state;
    logic [3:0] dstreak;
    logic       ilow;
    logic       dreq;
    logic       force_i;

    assign dreq    = dREN | dWEN;
    assign force_i = iREN && (dstreak == MAX_S);

    // ilow remembers whether iREN dropped at any point during the current data
    // grant, so only data accesses overlapped by a continuously held fetch count.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= IDLE;
            dstreak <= '0;
            ilow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (dreq && !force_i) begin
                        state <= DACC;
                        ilow  <= ~iREN;
                    end else if (iREN) begin
                        state <= IACC;
                    end
                end
                IACC: begin
                    if (ram_ready) begin
                        state   <= IDLE;
                        dstreak <= '0;
                    end else if (!iREN) begin
                        state <= IDLE;
                    end
                end
                DACC: begin
                    if (ram_ready) begin
                        state <= IDLE;
                        if (iREN && !ilow)
                            dstreak <= (dstreak == MAX_S) ? MAX_S : dstreak + 4'd1;
                        else
                            dstreak <= '0;
                    end else begin
                        ilow <= ilow | ~iREN;
                        if (!dreq)
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        ram_REN   = 1'b0;
        ram_WEN   = 1'b0;
        ram_addr  = iaddr;
        ram_store = dstore;
        iwait     = iREN;
        dwait     = dreq;
        iload     = ram_load;
        dload     = ram_load;
        case (state)
            IACC: begin
                ram_REN = iREN;
                iwait   = ~ram_ready;
            end
            DACC: begin
                ram_addr = daddr;
                ram_WEN  = dWEN;
                ram_REN  = dREN & ~dWEN;
                dwait    = ~ram_ready;
            end
            default: ;
        endcase
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port RAM between instruction fetch and data load/store requests.
- Sits between the fetch stage and RAM on one side, and the memory stage and RAM on the other.
- Data requests (load/store from the decoded dREN/dWEN) normally win. A starvation counter forces an instruction grant after MAX_DSTREAK consecutive data grants while a fetch is waiting.
- Each requester sees a wait/stall signal that drops for exactly one cycle when its access completes.

Parameters:
- ADDR_W, 32, width of all address buses
- WORD_W, 32, width of all data buses
- MAX_DSTREAK, 4, data completions allowed back-to-back while iREN is held before a fetch is forced; range 1..15

Ports:
- clk  in  1  clock; all state changes on rising edge
- n_rst  in  1  asynchronous active-low reset
- iREN  in  1  instruction read request, held until iwait low
- iaddr  in  ADDR_W  fetch address
- iwait  out  1  fetch stall; low only in the cycle the fetch completes
- iload  out  WORD_W  fetched word, valid when iREN=1 and iwait=0
- dREN  in  1  data read request, held until dwait low
- dWEN  in  1  data write request, held until dwait low
- daddr  in  ADDR_W  data address
- dstore  in  WORD_W  write data
- dwait  out  1  data stall; low only in the cycle the data access completes
- dload  out  WORD_W  read word, valid when dREN=1 and dwait=0
- ram_REN  out  1  RAM read enable
- ram_WEN  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_store  out  WORD_W  RAM write data
- ram_load  in  WORD_W  RAM read data
- ram_ready  in  1  RAM finished the current access (level, sampled each cycle)

Behaviour:
- State register: IDLE, IACC, DACC. Streak counter dstreak is 4 bits.
- Reset (n_rst low, asynchronous): state=IDLE, dstreak=0. This forces ram_REN=0 and ram_WEN=0.
- Output decode is combinational from state, requests and ram_ready. No output is registered.
- IDLE:
  - ram_REN=0, ram_WEN=0, ram_addr=iaddr, ram_store=dstore.
  - iwait=iREN; dwait=dREN|dWEN.
  - Next state: if (dREN|dWEN) and not (iREN and dstreak==MAX_DSTREAK), go to DACC. Else if iREN, go to IACC. Else stay in IDLE.
- IACC:
  - ram_REN=1, ram_addr=iaddr, iload=ram_load.
  - iwait = not ram_ready; dwait = dREN|dWEN.
  - On ram_ready: go to IDLE and set dstreak=0.
- DACC:
  - ram_addr=daddr, ram_store=dstore, ram_WEN=dWEN, ram_REN=dREN and not dWEN.
  - dREN and dWEN both high is treated as a write.
  - dload=ram_load; dwait = not ram_ready; iwait=iREN.
  - On ram_ready: go to IDLE. If iREN=1, dstreak increments, saturating at MAX_DSTREAK; else dstreak=0.
- iload and dload always pass ram_load through. They are meaningful only in the completion cycle.
- Latency: minimum 2 cycles per access (one IDLE arbitration cycle, then ram_ready in the first cycle of IACC/DACC). Every completion returns to IDLE, so back-to-back accesses have a 1-cycle bubble.
- Abort: if the granted request drops before ram_ready (IACC with iREN=0, or DACC with dREN=dWEN=0), return to IDLE next cycle. In that cycle RAM enables follow the inputs, i.e. they go 0. dstreak is unchanged.
- ram_ready while in IDLE is ignored.
- Reset mid-access: enables drop immediately, with no completion pulse, and dstreak clears.
- iREN low in any cycle while in IDLE or DACC clears dstreak on the next DACC completion. It never affects an in-flight grant.

Test Plan:
- Reset, iREN=1, iaddr=0x100, ram_ready high 2 cycles after grant, ram_load=0xDEADBEEF -> sequence IDLE, IACC (iwait=1), IACC (iwait=0, iload=0xDEADBEEF), IDLE. ram_REN=1 only in IACC.
- iREN and dREN both raised the same cycle, ram_ready=1 always -> DACC granted first (dwait low at cycle 2); IACC completes at cycle 4 (iwait low); dstreak=1 then 0.
- MAX_DSTREAK=2, iREN held, dWEN held for 3 stores, ram_ready=1 -> completion order D, D, I, D. During the forced I grant ram_REN=1 and ram_WEN=0.
- dREN=dWEN=1, daddr=0x40, dstore=0x12345678 -> ram_WEN=1, ram_REN=0, ram_addr=0x40, ram_store=0x12345678.
- In IACC with ram_ready=0, deassert iREN -> next cycle state=IDLE, ram_REN=0, no iwait-low pulse.
- Pull n_rst low mid-DACC without a clock edge -> ram_WEN and ram_REN fall immediately; after release, state=IDLE and dstreak=0.
